// File: rtl/bsg_cache_wh_mem_endpoint.sv
// Memory-side wormhole endpoint for vcache DMA packets: turns incoming packets into memory beats and returns read data.
// Optional BSG_CACHE_WH_MEM_ENDPOINT_CHECK_EN adds a sticky err_o for bad opcodes and header len mismatches.
module bsg_cache_wh_mem_endpoint
  #(parameter int addr_width_p    = 32
  , parameter int burst_len_p     = 4
  , parameter int mask_width_p    = 8
  , parameter int wh_flit_width_p = 64
  , parameter int wh_cid_width_p  = 4
  , parameter int wh_len_width_p  = 4
  , parameter int wh_cord_width_p = 8
  , localparam int words_per_beat_lp = mask_width_p/burst_len_p
  , localparam int link_width_lp     = wh_flit_width_p+2
  )
  (input  logic                         clk_i
  , input  logic                        reset_n_i
  , input  logic [link_width_lp-1:0]    wh_link_sif_i
  , output logic [link_width_lp-1:0]    wh_link_sif_o
  , input  logic [wh_cord_width_p-1:0]  my_wh_cord_i
  , input  logic [wh_cid_width_p-1:0]   my_wh_cid_i
  , output logic                        mem_v_o
  , output logic                        mem_w_o
  , output logic [addr_width_p-1:0]     mem_addr_o
  , output logic [wh_flit_width_p-1:0]  mem_data_o
  , output logic [words_per_beat_lp-1:0] mem_wmask_o
  , input  logic                        mem_ready_and_i
  , input  logic [wh_flit_width_p-1:0]  mem_data_i
  , input  logic                        mem_data_v_i
  , output logic                        mem_data_yumi_o
`ifdef BSG_CACHE_WH_MEM_ENDPOINT_CHECK_EN
  , output logic                        err_o
`endif
  );

  // state     | meaning
  // RECV_HDR  | waiting for header flit
  // RECV_ADDR | waiting for address flit
  // RECV_MASK | waiting for mask flit (masked write)
  // WRITE     | forwarding data flits to memory
  // RESP_HDR  | sending read response header
  // READ      | issuing read beats and returning data
  localparam logic [2:0] RECV_HDR  = 3'd0;
  localparam logic [2:0] RECV_ADDR = 3'd1;
  localparam logic [2:0] RECV_MASK = 3'd2;
  localparam logic [2:0] WRITE     = 3'd3;
  localparam logic [2:0] RESP_HDR  = 3'd4;
  localparam logic [2:0] READ      = 3'd5;

  localparam int len_lsb_lp      = wh_cord_width_p;
  localparam int cid_lsb_lp      = len_lsb_lp + wh_len_width_p;
  localparam int src_cord_lsb_lp = cid_lsb_lp + wh_cid_width_p;
  localparam int src_cid_lsb_lp  = src_cord_lsb_lp + wh_cord_width_p;
  localparam int op_lsb_lp       = src_cid_lsb_lp + wh_cid_width_p;
  localparam int cnt_width_lp    = $clog2(burst_len_p+1);
  localparam logic [addr_width_p-1:0] bytes_per_flit_lp = addr_width_p'(wh_flit_width_p/8);
  localparam logic [cnt_width_lp-1:0] last_beat_lp      = cnt_width_lp'(burst_len_p-1);
  localparam logic [cnt_width_lp-1:0] burst_cnt_lp      = cnt_width_lp'(burst_len_p);

  logic                       in_v, in_ready, out_v, out_ready;
  logic [wh_flit_width_p-1:0] in_data, out_data, resp_hdr;

  assign in_v      = wh_link_sif_i[link_width_lp-1];
  assign in_data   = wh_link_sif_i[link_width_lp-2:1];
  assign out_ready = wh_link_sif_i[0];
  assign wh_link_sif_o = {out_v, out_data, in_ready};

  logic [2:0]                 state_r;
  logic [wh_cord_width_p-1:0] src_cord_r;
  logic [wh_cid_width_p-1:0]  src_cid_r;
  logic [1:0]                 opcode_r;
  logic [addr_width_p-1:0]    addr_r;
  logic [mask_width_p-1:0]    mask_r, mask_shift;
  logic [cnt_width_lp-1:0]    req_beat_r, rsp_beat_r;

  logic [1:0]                hdr_op;
  logic [wh_len_width_p-1:0] hdr_len;
  logic                      in_hs;

  assign hdr_op  = in_data[op_lsb_lp +: 2];
  assign hdr_len = in_data[len_lsb_lp +: wh_len_width_p];
  assign in_hs   = in_v & in_ready;

  assign mem_addr_o = addr_r + addr_width_p'(req_beat_r) * bytes_per_flit_lp;
  assign mem_data_o = in_data;
  assign mask_shift = mask_r >> (req_beat_r * words_per_beat_lp);

  always_comb begin
    resp_hdr = '0;
    resp_hdr[0 +: wh_cord_width_p]               = src_cord_r;
    resp_hdr[len_lsb_lp +: wh_len_width_p]       = wh_len_width_p'(burst_len_p);
    resp_hdr[cid_lsb_lp +: wh_cid_width_p]       = src_cid_r;
    resp_hdr[src_cord_lsb_lp +: wh_cord_width_p] = my_wh_cord_i;
    resp_hdr[src_cid_lsb_lp +: wh_cid_width_p]   = my_wh_cid_i;
  end

  always_comb begin
    in_ready        = 1'b0;
    out_v           = 1'b0;
    out_data        = '0;
    mem_v_o         = 1'b0;
    mem_w_o         = 1'b0;
    mem_wmask_o     = '0;
    mem_data_yumi_o = 1'b0;
    case (state_r)
      RECV_HDR, RECV_ADDR, RECV_MASK: in_ready = 1'b1;
      WRITE: begin
        in_ready    = mem_ready_and_i;
        mem_v_o     = in_v;
        mem_w_o     = 1'b1;
        mem_wmask_o = mask_shift[words_per_beat_lp-1:0];
      end
      RESP_HDR: begin
        out_v    = 1'b1;
        out_data = resp_hdr;
      end
      READ: begin
        mem_v_o         = (req_beat_r < burst_cnt_lp);
        out_v           = mem_data_v_i;
        out_data        = mem_data_i;
        mem_data_yumi_o = mem_data_v_i & out_ready;
      end
      default: ;
    endcase
  end

`ifdef BSG_CACHE_WH_MEM_ENDPOINT_CHECK_EN
  logic                      err_r;
  logic [wh_len_width_p-1:0] exp_len;
  assign err_o = err_r;
  always_comb begin
    case (hdr_op)
      2'd0:    exp_len = wh_len_width_p'(1);
      2'd1:    exp_len = wh_len_width_p'(burst_len_p+1);
      2'd2:    exp_len = wh_len_width_p'(burst_len_p+2);
      default: exp_len = '0;
    endcase
  end
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= RECV_HDR;
      src_cord_r <= '0;
      src_cid_r  <= '0;
      opcode_r   <= '0;
      addr_r     <= '0;
      mask_r     <= '0;
      req_beat_r <= '0;
      rsp_beat_r <= '0;
`ifdef BSG_CACHE_WH_MEM_ENDPOINT_CHECK_EN
      err_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        RECV_HDR: if (in_hs) begin
          src_cord_r <= in_data[src_cord_lsb_lp +: wh_cord_width_p];
          src_cid_r  <= in_data[src_cid_lsb_lp +: wh_cid_width_p];
          opcode_r   <= hdr_op;
          // opcode 3 is dropped here: only the header is consumed
          if (hdr_op != 2'd3) state_r <= RECV_ADDR;
`ifdef BSG_CACHE_WH_MEM_ENDPOINT_CHECK_EN
          if (hdr_op == 2'd3 || hdr_len != exp_len) begin
            err_r <= 1'b1;
            $error("bsg_cache_wh_mem_endpoint: bad header op=%0d len=%0d", hdr_op, hdr_len);
          end
`endif
        end
        RECV_ADDR: if (in_hs) begin
          addr_r <= in_data[addr_width_p-1:0];
          mask_r <= '1;
          case (opcode_r)
            2'd1:    state_r <= WRITE;
            2'd2:    state_r <= RECV_MASK;
            default: state_r <= RESP_HDR;
          endcase
        end
        RECV_MASK: if (in_hs) begin
          mask_r  <= in_data[mask_width_p-1:0];
          state_r <= WRITE;
        end
        WRITE: if (in_hs) begin
          if (req_beat_r == last_beat_lp) begin
            req_beat_r <= '0;
            state_r    <= RECV_HDR;
          end else begin
            req_beat_r <= req_beat_r + 1'b1;
          end
        end
        RESP_HDR: if (out_ready) state_r <= READ;
        READ: begin
          if (mem_v_o && mem_ready_and_i) req_beat_r <= req_beat_r + 1'b1;
          if (mem_data_yumi_o) begin
            if (rsp_beat_r == last_beat_lp) begin
              req_beat_r <= '0;
              rsp_beat_r <= '0;
              state_r    <= RECV_HDR;
            end else begin
              rsp_beat_r <= rsp_beat_r + 1'b1;
            end
          end
        end
        default: state_r <= RECV_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_cache_wh_mem_endpoint.sv
// Directed bench for bsg_cache_wh_mem_endpoint: table of write packets plus hand sequences for reads, backpressure, drop and reset.
module tb_bsg_cache_wh_mem_endpoint;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        in_v, out_ready;
  logic [63:0] in_data;
  logic [65:0] link_i, link_o;
  logic        mem_v_o, mem_w_o, mem_ready_and_i, mem_data_v_i, mem_data_yumi_o;
  logic [31:0] mem_addr_o;
  logic [63:0] mem_data_o, mem_data_i;
  logic [1:0]  mem_wmask_o;
`ifdef BSG_CACHE_WH_MEM_ENDPOINT_CHECK_EN
  logic        err_o;
`endif

  always #5 clk_i = ~clk_i;
  assign link_i = {in_v, in_data, out_ready};

  bsg_cache_wh_mem_endpoint dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .wh_link_sif_i(link_i), .wh_link_sif_o(link_o),
    .my_wh_cord_i(8'h5A), .my_wh_cid_i(4'h7),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_wmask_o(mem_wmask_o),
    .mem_ready_and_i(mem_ready_and_i), .mem_data_i(mem_data_i),
    .mem_data_v_i(mem_data_v_i), .mem_data_yumi_o(mem_data_yumi_o)
`ifdef BSG_CACHE_WH_MEM_ENDPOINT_CHECK_EN
    , .err_o(err_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input logic [1:0] op, input logic [3:0] len,
                                         input logic [7:0] src_cord, input logic [3:0] src_cid);
    return {34'b0, op, src_cid, src_cord, 4'h0, len, 8'h5A};
  endfunction

  function automatic logic [63:0] data_for(input logic [31:0] a);
    return {~a, a};
  endfunction

  task automatic send_flit(input logic [63:0] d);
    @(negedge clk_i);
    in_v = 1'b1;
    in_data = d;
    #1;
    chk("flit_ready", link_o[0], 1'b1);
    @(posedge clk_i);
    #1 in_v = 1'b0;
  endtask

  typedef struct packed {
    logic [1:0]        op;
    logic [3:0]        len;
    logic [31:0]       addr;
    logic [7:0]        mask;
    logic [2:0]        stall;   // beat index held off one cycle by memory; 4 = none
    logic [0:3][31:0]  ea;
    logic [0:3][1:0]   em;
  } wvec_t;

  wvec_t wv[4];

  task automatic do_write(input wvec_t v, input int idx);
    logic [63:0] d;
    send_flit(mk_hdr(v.op, v.len, 8'h21, 4'h1));
    send_flit({32'h0, v.addr});
    if (v.op == 2'd2) send_flit({56'h0, v.mask});
    for (int b = 0; b < 4; b++) begin
      d = 64'hD0D0_0000_0000_0000 | 64'(b) | (64'(idx) << 8);
      @(negedge clk_i);
      in_v = 1'b1;
      in_data = d;
      if (b == int'(v.stall)) begin
        mem_ready_and_i = 1'b0;
        #1;
        chk("wr_stall_ready", link_o[0], 1'b0);
        @(negedge clk_i);
        mem_ready_and_i = 1'b1;
      end
      #1;
      chk("wr_mem_v", mem_v_o, 1'b1);
      chk("wr_mem_w", mem_w_o, 1'b1);
      chk("wr_addr", mem_addr_o, v.ea[b]);
      chk("wr_wmask", mem_wmask_o, v.em[b]);
      chk("wr_data", mem_data_o, d);
      chk("wr_out_v", link_o[65], 1'b0);
      @(posedge clk_i);
      #1 in_v = 1'b0;
    end
    @(negedge clk_i);
    #1;
    chk("wr_done_ready", link_o[0], 1'b1);
    chk("wr_done_mem_v", mem_v_o, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int stall_start, input int stall_len);
    logic [63:0] q[$];
    int req_i = 0;
    int rsp_i = 0;
    send_flit(mk_hdr(2'd0, 4'd1, 8'h12, 4'h3));
    send_flit({32'h0, addr});
    @(negedge clk_i);
    #1;
    chk("rsp_hdr_v", link_o[65], 1'b1);
    chk("rsp_hdr", link_o[64:1], 64'h0000_0000_075A_3412);
    chk("rsp_hdr_in_ready", link_o[0], 1'b0);
    @(posedge clk_i);
    for (int c = 0; c < 60 && rsp_i < 4; c++) begin
      @(negedge clk_i);
      out_ready = !(c >= stall_start && c < stall_start + stall_len);
      mem_data_v_i = (q.size() > 0);
      mem_data_i = (q.size() > 0) ? q[0] : 64'h0;
      #1;
      if (mem_data_v_i && !out_ready) chk("rd_yumi_bp", mem_data_yumi_o, 1'b0);
      if (mem_data_yumi_o) begin
        chk("rd_out_v", link_o[65], 1'b1);
        chk("rd_out_data", link_o[64:1], q[0]);
        void'(q.pop_front());
        rsp_i++;
      end
      if (mem_v_o) begin
        if (req_i >= 4) chk("rd_extra_req", 1'b1, 1'b0);
        else begin
          chk("rd_mem_w", mem_w_o, 1'b0);
          chk("rd_addr", mem_addr_o, addr + 32'(req_i * 8));
          q.push_back(data_for(addr + 32'(req_i * 8)));
          req_i++;
        end
      end
    end
    chk("rd_beats_returned", 64'(rsp_i), 64'd4);
    chk("rd_beats_issued", 64'(req_i), 64'd4);
    @(negedge clk_i);
    mem_data_v_i = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rd_done_ready", link_o[0], 1'b1);
    chk("rd_done_out_v", link_o[65], 1'b0);
  endtask

  initial begin
    wv[0] = '{op:2'd1, len:4'd5, addr:32'h40, mask:8'hFF, stall:3'd4,
              ea:{32'h40, 32'h48, 32'h50, 32'h58}, em:{2'b11, 2'b11, 2'b11, 2'b11}};
    wv[1] = '{op:2'd2, len:4'd6, addr:32'h200, mask:8'b0110_1001, stall:3'd1,
              ea:{32'h200, 32'h208, 32'h210, 32'h218}, em:{2'b01, 2'b10, 2'b10, 2'b01}};
    wv[2] = '{op:2'd1, len:4'd5, addr:32'hFFFF_FFF8, mask:8'hFF, stall:3'd4,
              ea:{32'hFFFF_FFF8, 32'h0, 32'h8, 32'h10}, em:{2'b11, 2'b11, 2'b11, 2'b11}};
    wv[3] = '{op:2'd2, len:4'd6, addr:32'h1000, mask:8'hF0, stall:3'd3,
              ea:{32'h1000, 32'h1008, 32'h1010, 32'h1018}, em:{2'b00, 2'b00, 2'b11, 2'b11}};

    reset_n_i = 1'b0;
    in_v = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    mem_ready_and_i = 1'b1;
    mem_data_v_i = 1'b0;
    mem_data_i = '0;
    #1;
    chk("rst_mem_v", mem_v_o, 1'b0);
    chk("rst_yumi", mem_data_yumi_o, 1'b0);
    chk("rst_out_v", link_o[65], 1'b0);
    chk("rst_in_ready", link_o[0], 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    do_read(32'h100, 100, 0);
    for (int i = 0; i < 4; i++) do_write(wv[i], i);
    do_read(32'h2000, 2, 10);

    // opcode 3 header is swallowed and the endpoint stays ready for a new header
    send_flit(mk_hdr(2'd3, 4'd1, 8'h33, 4'h2));
    @(negedge clk_i);
    #1;
    chk("drop_in_ready", link_o[0], 1'b1);
    chk("drop_mem_v", mem_v_o, 1'b0);
    chk("drop_out_v", link_o[65], 1'b0);
`ifdef BSG_CACHE_WH_MEM_ENDPOINT_CHECK_EN
    chk("drop_err", err_o, 1'b1);
`endif

    send_flit(mk_hdr(2'd1, 4'd5, 8'h21, 4'h1));
    send_flit(64'h80);
    for (int b = 0; b < 2; b++) send_flit(64'hBEEF_0000 | 64'(b));
    @(negedge clk_i);
    in_v = 1'b1;
    in_data = 64'hBEEF_0002;
    #1;
    chk("abort_pre_mem_v", mem_v_o, 1'b1);
    chk("abort_pre_addr", mem_addr_o, 32'h90);
    reset_n_i = 1'b0;
    #1;
    chk("abort_mem_v", mem_v_o, 1'b0);
    chk("abort_out_v", link_o[65], 1'b0);
    chk("abort_yumi", mem_data_yumi_o, 1'b0);
    chk("abort_in_ready", link_o[0], 1'b1);
    @(negedge clk_i);
    in_v = 1'b0;
    reset_n_i = 1'b1;
    do_read(32'h100, 100, 0);
`ifdef BSG_CACHE_WH_MEM_ENDPOINT_CHECK_EN
    chk("after_reset_err", err_o, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
